// File: rtl/crc16_tx_framer.sv
// Transmit framer: forwards 16-bit words and appends a CRC-16/CCITT word (init 0xFFFF) per frame.
// Optional `define CRC_FRAMER_HDR_EN prefixes each frame with SOF_WORD (excluded from the CRC).
module crc16_tx_framer #(
    parameter int unsigned MAX_WORDS = 256
`ifdef CRC_FRAMER_HDR_EN
    ,
    parameter logic [15:0] SOF_WORD = 16'hEB90
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] m_data,
    output logic        m_last,
    output logic        trunc_err,
    output logic [15:0] frame_cnt
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam logic [DW-1:0] CRC_INIT = 16'hFFFF;
    localparam logic [DW-1:0] CRC_POLY = 16'h1021;

`ifdef CRC_FRAMER_HDR_EN
    typedef enum logic [1:0] {IDLE, DATA, CRC, HDR} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
`endif

    // 16 serial MSB-first shifts of (crc ^ data) with zero feed-in
    function automatic logic [DW-1:0] crc_step(input logic [DW-1:0] x);
        logic [DW-1:0] c;
        c = x;
        for (int i = 0; i < 16; i++) begin
            c = c[DW-1] ? (DW'(c << 1) ^ CRC_POLY) : DW'(c << 1);
        end
        return c;
    endfunction

    state_t        state_q;
    logic [DW-1:0] crc_q;
    logic [CW-1:0] word_cnt_q;
    logic          m_valid_q;
    logic [DW-1:0] m_data_q;
    logic          m_last_q;
    logic          trunc_err_q;
    logic [15:0]   frame_cnt_q;

    logic          out_free;
    logic          s_fire;
    logic [DW-1:0] crc_d;
    logic [CW-1:0] word_cnt_d;

    assign out_free   = !m_valid_q || m_ready;
`ifdef CRC_FRAMER_HDR_EN
    assign s_ready    = (state_q == DATA) && out_free;
`else
    assign s_ready    = ((state_q == IDLE) || (state_q == DATA)) && out_free;
`endif
    assign s_fire     = s_valid && s_ready;
    assign crc_d      = crc_step(crc_q ^ s_data);
    assign word_cnt_d = CW'(word_cnt_q + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            word_cnt_q  <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            trunc_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            trunc_err_q <= 1'b0;
            if (m_valid_q && m_ready && m_last_q) begin
                frame_cnt_q <= 16'(frame_cnt_q + 1'b1);
            end
            // Output register drains when accepted; loads below override
            if (out_free) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
`ifdef CRC_FRAMER_HDR_EN
                    if (s_valid) begin
                        state_q <= HDR;
                    end
`else
                    if (s_fire) begin
                        m_valid_q  <= 1'b1;
                        m_data_q   <= s_data;
                        m_last_q   <= 1'b0;
                        crc_q      <= crc_d;
                        word_cnt_q <= word_cnt_d;
                        state_q    <= s_last ? CRC : DATA;
                    end
`endif
                end
`ifdef CRC_FRAMER_HDR_EN
                HDR: begin
                    if (out_free) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= SOF_WORD;
                        m_last_q  <= 1'b0;
                        state_q   <= DATA;
                    end
                end
`endif
                DATA: begin
                    if (s_fire) begin
                        m_valid_q  <= 1'b1;
                        m_data_q   <= s_data;
                        m_last_q   <= 1'b0;
                        crc_q      <= crc_d;
                        word_cnt_q <= word_cnt_d;
                        if (s_last) begin
                            state_q <= CRC;
                        end else if (word_cnt_d == CW'(MAX_WORDS)) begin
                            state_q     <= CRC;
                            trunc_err_q <= 1'b1;
                        end
                    end
                end
                CRC: begin
                    // Return to IDLE as the CRC loads so the next frame starts without a bubble
                    if (out_free) begin
                        m_valid_q  <= 1'b1;
                        m_data_q   <= crc_q;
                        m_last_q   <= 1'b1;
                        crc_q      <= CRC_INIT;
                        word_cnt_q <= '0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign trunc_err = trunc_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_crc16_tx_framer.sv
// Scoreboard bench for crc16_tx_framer (MAX_WORDS=4); directed frames with hand-computed CRCs.
// CRC references: M(0x0000)=0x0000, M(0x0001)=0x1021, M(0x0002)=0x2042.
module tb_crc16_tx_framer;

    localparam int unsigned MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        trunc_err;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    int          xfer_cyc[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          trunc_seen = 0;
    int          exp_frames = 0;
    bit          toggle_mode = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 1'b0;

`ifdef CRC_FRAMER_HDR_EN
    localparam logic IDLE_READY = 1'b0;
    localparam int   HDR_WORDS = 1;
`else
    localparam logic IDLE_READY = 1'b1;
    localparam int   HDR_WORDS = 0;
`endif

    crc16_tx_framer #(.MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .trunc_err(trunc_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic exp_word(input logic [15:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        sb.push_back(e);
    endtask

    task automatic exp_sof();
`ifdef CRC_FRAMER_HDR_EN
        exp_word(16'hEB90, 1'b0);
`endif
    endtask

    // Monitor: a transfer occurs at the posedge following a negedge with m_valid & m_ready
    initial begin
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_data", {15'd0, prev_data, prev_last}, {15'd0, m_data, m_last});
            end
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got %0h last=%0b with empty scoreboard", m_data, m_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_word", {15'd0, m_data, m_last}, {15'd0, e.d, e.l});
                end
                xfer_cyc.push_back(cyc);
            end
            if (trunc_err) trunc_seen++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = toggle_mode ? ~m_ready : 1'b1;
        end
    end

    task automatic send_word(input logic [15:0] d, input logic l);
        int waited;
        bit ok;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        waited  = 0;
        ok      = 1'b0;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
            waited++;
        end
        if (!ok) chk("s_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_left", sb.size(), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 16'h0);
        chk("rst_trunc", trunc_err, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'h0);
        chk("rst_s_ready", s_ready, IDLE_READY);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame {FFFF,0000,0000}: CRC 0000, all outputs back to back
        exp_sof();
        exp_word(16'hFFFF, 1'b0); exp_word(16'h0000, 1'b0);
        exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b1);
        xfer_cyc.delete();
        send_word(16'hFFFF, 1'b0); send_word(16'h0000, 1'b0); send_word(16'h0000, 1'b1);
        drain();
        chk("f1_xfers", xfer_cyc.size(), 32'(4 + HDR_WORDS));
        if (xfer_cyc.size() > 0) chk("f1_span", 32'(xfer_cyc[$] - xfer_cyc[0]), 32'(3 + HDR_WORDS));
        exp_frames++;
        chk("f1_frame_cnt", frame_cnt, 32'(exp_frames));

        // Single-word frames with nonzero CRCs
        exp_sof(); exp_word(16'hFFFF, 1'b0); exp_word(16'h0000, 1'b1);
        send_word(16'hFFFF, 1'b1);
        exp_sof(); exp_word(16'hFFFE, 1'b0); exp_word(16'h1021, 1'b1);
        send_word(16'hFFFE, 1'b1);
        exp_sof(); exp_word(16'hFFFD, 1'b0); exp_word(16'h2042, 1'b1);
        send_word(16'hFFFD, 1'b1);
        drain();
        exp_frames += 3;
        chk("single_frame_cnt", frame_cnt, 32'(exp_frames));

        // Backpressure: m_ready toggling, same words expected, stalls held stable
        toggle_mode = 1'b1;
        exp_sof(); exp_word(16'hFFFF, 1'b0); exp_word(16'h0000, 1'b1);
        send_word(16'hFFFF, 1'b1);
        exp_sof(); exp_word(16'hFFFE, 1'b0); exp_word(16'h1021, 1'b0);
        exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b1);
        send_word(16'hFFFE, 1'b0); send_word(16'h1021, 1'b0); send_word(16'h0000, 1'b1);
        drain();
        toggle_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_frames += 2;
        chk("toggle_frame_cnt", frame_cnt, 32'(exp_frames));

        // Truncation at MAX_WORDS=4, then words 5..7 form a new frame
        exp_sof();
        exp_word(16'hFFFF, 1'b0); exp_word(16'h0000, 1'b0);
        exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b1);
        exp_sof();
        exp_word(16'hFFFE, 1'b0); exp_word(16'h1021, 1'b0);
        exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b1);
        send_word(16'hFFFF, 1'b0); send_word(16'h0000, 1'b0);
        send_word(16'h0000, 1'b0); send_word(16'h0000, 1'b0);
        send_word(16'hFFFE, 1'b0); send_word(16'h1021, 1'b0);
        send_word(16'h0000, 1'b1);
        drain();
        exp_frames += 2;
        chk("trunc_frame_cnt", frame_cnt, 32'(exp_frames));
        chk("trunc_pulses", trunc_seen, 32'd1);

        // s_last on word MAX_WORDS is a normal close
        exp_sof();
        exp_word(16'hFFFF, 1'b0); exp_word(16'h0000, 1'b0);
        exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b0); exp_word(16'h0000, 1'b1);
        send_word(16'hFFFF, 1'b0); send_word(16'h0000, 1'b0);
        send_word(16'h0000, 1'b0); send_word(16'h0000, 1'b1);
        drain();
        exp_frames++;
        chk("boundary_frame_cnt", frame_cnt, 32'(exp_frames));
        chk("boundary_no_trunc", trunc_seen, 32'd1);

        // Reset after 2 words: second word is dropped from the output register
        exp_sof();
        exp_word(16'hFFFF, 1'b0);
        send_word(16'hFFFF, 1'b0); send_word(16'h0000, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_s_ready", s_ready, IDLE_READY);
        chk("midrst_frame_cnt", frame_cnt, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_frames = 0;
        chk("midrst_sb_empty", sb.size(), 32'd0);
        sb.delete();
        exp_sof(); exp_word(16'hFFFF, 1'b0); exp_word(16'h0000, 1'b1);
        send_word(16'hFFFF, 1'b1);
        drain();
        exp_frames++;
        chk("post_rst_frame_cnt", frame_cnt, 32'(exp_frames));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
